// File: rtl/viterbi_acs.sv
// Add-compare-select / path-metric stage for a 4-state (K=3) Viterbi decoder.
// Define VITERBI_ACS_BEST_STATE_EN to build the registered minimum-metric state output.
module viterbi_acs #(
  parameter int unsigned PM_W    = 8,
  parameter int unsigned INIT_PM = 32,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refresh,
  input  logic             valid_in,
  input  logic [3:0]       branch_metric_00_0,
  input  logic [3:0]       branch_metric_00_1,
  input  logic [3:0]       branch_metric_01_0,
  input  logic [3:0]       branch_metric_01_1,
  input  logic [3:0]       branch_metric_10_0,
  input  logic [3:0]       branch_metric_10_1,
  input  logic [3:0]       branch_metric_11_0,
  input  logic [3:0]       branch_metric_11_1,
  output logic [PM_W-1:0]  pm_00,
  output logic [PM_W-1:0]  pm_01,
  output logic [PM_W-1:0]  pm_10,
  output logic [PM_W-1:0]  pm_11,
  output logic [3:0]       decision,
  output logic [1:0]       best_state,
  output logic [CNT_W-1:0] step_cnt,
  output logic             first_out,
  output logic             norm_evt,
  output logic             valid_out
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PM_W-1:0]   r_pm [4];
  logic [3:0]        r_decision;
  logic [CNT_W-1:0]  r_step_cnt;
  logic              r_first;
  logic              r_norm;
  logic              r_valid;
  logic [1:0]        r_best;

  logic [3:0]        w_bm [4][2];
  logic [PM_W-1:0]   w_base [4];
  logic [PM_W:0]     w_cand0 [4];
  logic [PM_W:0]     w_cand1 [4];
  logic [PM_W-1:0]   w_sat0 [4];
  logic [PM_W-1:0]   w_sat1 [4];
  logic [PM_W-1:0]   w_sel [4];
  logic [PM_W-1:0]   w_new [4];
  logic [3:0]        w_dec;
  logic              w_norm;
  logic              w_first;

  assign w_bm[0][0] = branch_metric_00_0;
  assign w_bm[0][1] = branch_metric_00_1;
  assign w_bm[1][0] = branch_metric_01_0;
  assign w_bm[1][1] = branch_metric_01_1;
  assign w_bm[2][0] = branch_metric_10_0;
  assign w_bm[2][1] = branch_metric_10_1;
  assign w_bm[3][0] = branch_metric_11_0;
  assign w_bm[3][1] = branch_metric_11_1;

  // A refresh coinciding with a valid step runs the ACS from the init metrics.
  always_comb begin
    w_base[0] = refresh ? '0 : r_pm[0];
    w_base[1] = refresh ? INIT_V : r_pm[1];
    w_base[2] = refresh ? INIT_V : r_pm[2];
    w_base[3] = refresh ? INIT_V : r_pm[3];
  end

  // Next state s' = {b, s[1]}: predecessors {s'[0],0} and {s'[0],1}, input b = s'[1].
  always_comb begin
    w_dec = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      w_cand0[s] = {1'b0, w_base[(s % 2) * 2]}
                 + (PM_W+1)'(w_bm[(s % 2) * 2][s / 2]);
      w_cand1[s] = {1'b0, w_base[(s % 2) * 2 + 1]}
                 + (PM_W+1)'(w_bm[(s % 2) * 2 + 1][s / 2]);
      w_sat0[s]  = w_cand0[s][PM_W] ? '1 : w_cand0[s][PM_W-1:0];
      w_sat1[s]  = w_cand1[s][PM_W] ? '1 : w_cand1[s][PM_W-1:0];
      w_dec[s]   = (w_sat1[s] < w_sat0[s]);
      w_sel[s]   = w_dec[s] ? w_sat1[s] : w_sat0[s];
    end
  end

  assign w_norm = w_sel[0][PM_W-1] & w_sel[1][PM_W-1]
                & w_sel[2][PM_W-1] & w_sel[3][PM_W-1];

  always_comb begin
    for (int unsigned s = 0; s < 4; s++) begin
      w_new[s] = w_norm ? {1'b0, w_sel[s][PM_W-2:0]} : w_sel[s];
    end
  end

  assign w_first = refresh || (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    if (valid_in) begin
      w_state_nxt = S_RUN;
    end else if (refresh) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pm[0]    <= '0;
      r_pm[1]    <= INIT_V;
      r_pm[2]    <= INIT_V;
      r_pm[3]    <= INIT_V;
      r_decision <= '0;
      r_step_cnt <= '0;
      r_first    <= 1'b0;
      r_norm     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= valid_in;
      r_first <= 1'b0;
      r_norm  <= 1'b0;
      if (valid_in) begin
        for (int unsigned s = 0; s < 4; s++) begin
          r_pm[s] <= w_new[s];
        end
        r_decision <= w_dec;
        r_norm     <= w_norm;
        r_first    <= w_first;
        r_step_cnt <= w_first ? '0 : r_step_cnt + CNT_W'(1);
      end else if (refresh) begin
        r_pm[0]    <= '0;
        r_pm[1]    <= INIT_V;
        r_pm[2]    <= INIT_V;
        r_pm[3]    <= INIT_V;
        r_step_cnt <= '0;
      end
    end
  end

`ifdef VITERBI_ACS_BEST_STATE_EN
  logic [1:0]      w_min01;
  logic [1:0]      w_min23;
  logic [PM_W-1:0] w_v01;
  logic [PM_W-1:0] w_v23;
  logic [1:0]      w_best;

  // Strict less-than keeps the lower index on ties at every level of the tree.
  always_comb begin
    w_min01 = (w_new[1] < w_new[0]) ? 2'd1 : 2'd0;
    w_v01   = (w_new[1] < w_new[0]) ? w_new[1] : w_new[0];
    w_min23 = (w_new[3] < w_new[2]) ? 2'd3 : 2'd2;
    w_v23   = (w_new[3] < w_new[2]) ? w_new[3] : w_new[2];
    w_best  = (w_v23 < w_v01) ? w_min23 : w_min01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_best <= '0;
    end else if (valid_in) begin
      r_best <= w_best;
    end
  end
`else
  assign r_best = '0;
`endif

  assign pm_00      = r_pm[0];
  assign pm_01      = r_pm[1];
  assign pm_10      = r_pm[2];
  assign pm_11      = r_pm[3];
  assign decision   = r_decision;
  assign best_state = r_best;
  assign step_cnt   = r_step_cnt;
  assign first_out  = r_first;
  assign norm_evt   = r_norm;
  assign valid_out  = r_valid;

endmodule

// File: doc/viterbi_acs.md
Name: viterbi_acs

Overview:
- Add-compare-select / path-metric stage for the 4-state (K=3) Viterbi decoder. Sits directly downstream of the branch metric unit (bmu).
- Each valid cycle it consumes the bmu's eight 4-bit per-state, per-input-bit branch metrics and updates four path metrics.
- It emits one survivor decision bit per state to the traceback unit.
- It keeps a step counter and a frame-start flag so traceback can align frames.

Parameters:
- PM_W, 8: path metric width in bits (min 6).
- INIT_PM, 32: value loaded into states 01/10/11 on reset/refresh. State 00 is loaded with 0. Must be < 2^(PM_W-1).
- CNT_W, 8: width of step counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- refresh  in  1  start new frame: reinitialise path metrics and counter
- valid_in  in  1  branch metrics valid (bmu valid_out)
- branch_metric_00_0 .. branch_metric_11_1  in  4 each  metric of the branch leaving state XY with input bit b (eight ports, bmu outputs)
- pm_00, pm_01, pm_10, pm_11  out  PM_W each  current path metrics
- decision  out  4  survivor bits: bit s = 1 if state s chose its predecessor with LSB=1
- best_state  out  2  state with minimum path metric (optional feature)
- step_cnt  out  CNT_W  index of the step reported by decision
- first_out  out  1  decision belongs to step 0 of a frame
- norm_evt  out  1  normalisation applied on this step
- valid_out  out  1  decision/pm/step_cnt valid

Behaviour:
- Trellis:
  - State = last two input bits, newest in MSB.
  - Next state s' = {b, s[1]}.
  - Predecessors of s' are {s'[0],0} (decision 0) and {s'[0],1} (decision 1), reached with input b = s'[1].
  - s'=00: pm_00+bm_00_0 vs pm_01+bm_01_0.
  - s'=01: pm_10+bm_10_0 vs pm_11+bm_11_0.
  - s'=10: pm_00+bm_00_1 vs pm_01+bm_01_1.
  - s'=11: pm_10+bm_10_1 vs pm_11+bm_11_1.
- Arithmetic:
  - Candidates are computed in PM_W+1 bits with the branch metric zero-extended.
  - A candidate > 2^PM_W-1 saturates to 2^PM_W-1.
  - The smaller candidate wins. On a tie, decision 0 (lower predecessor) wins.
- Normalisation: if all four selected metrics have bit PM_W-1 set, subtract 2^(PM_W-1) from each before registering, and set norm_evt=1 for that step.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N, with valid_out=1 for exactly one cycle per valid_in.
- valid_in=0:
  - Path metrics and step_cnt hold.
  - valid_out=0 on the next cycle.
  - decision holds its last value.
- Internal states: IDLE (metrics at init, no step taken yet in frame) and RUN.
  - IDLE -> RUN on the first valid_in. That step outputs first_out=1 and step_cnt=0.
  - In RUN, step_cnt increments per valid step and wraps from 2^CNT_W-1 to 0. A wrap does not raise first_out.
- refresh (with valid_in=0):
  - Load pm_00=0 and others=INIT_PM. Go to IDLE and clear step_cnt.
  - valid_out=0 next cycle.
- refresh and valid_in in the same cycle: the ACS uses the init metrics rather than the stored ones. Outputs that step with first_out=1, step_cnt=0, and state RUN.
- Reset:
  - pm_00=0, others=INIT_PM. decision=0, best_state=0, step_cnt=0.
  - first_out=0, norm_evt=0, valid_out=0. State IDLE.
  - rst has priority over refresh and valid_in.
  - A reset mid-stream discards any in-flight step: valid_out=0 the cycle after rst.
- norm_evt and first_out are qualified by valid_out and are 0 when valid_out=0.

Optional Feature:
- Macro: VITERBI_ACS_BEST_STATE_EN.
- Defined: best_state is registered with the selected metrics. It is the index of the minimum of the four new metrics, with ties going to the lowest index, and updates only on valid steps.
- Undefined: best_state is tied to 2'b00 and the comparator tree is not built.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then one valid step from init [0,32,32,32] with bm_00_0=0, bm_00_1=2, bm_01_0=1, bm_01_1=1, bm_10_0=2, bm_10_1=0, bm_11_0=1, bm_11_1=1 -> next cycle:
  - valid_out=1; pm=[0,33,2,32]; decision=4'b0010.
  - first_out=1; step_cnt=0; best_state=00 (if enabled).
- All pm equal (after the above, refresh, and INIT_PM override to 0 in a build) with all bm=0 -> decision=4'b0000 (tie to lower predecessor) and pm unchanged.
- Drive all bm=15 continuously -> on the first step where all selected metrics are >=128: norm_evt=1 and every pm equals its candidate minus 128. No pm ever wraps.
- valid_in pattern 1,0,0,1 -> valid_out 0,1,0,0,1. pm and step_cnt hold across the gap. step_cnt goes 0 then 1.
- refresh alone mid-frame, then valid -> pm reloaded to [0,32,32,32], then first_out=1 and step_cnt=0. refresh+valid in the same cycle gives the same output as refresh followed by valid.
- rst asserted together with valid_in and refresh mid-stream -> next cycle: all outputs at reset values and valid_out=0. 260 consecutive valid steps -> step_cnt wraps 255->0 with first_out=0.
